// File: rtl/popcnt_frame_acc_if.sv
// Handshake bundle between the popcount unit, the frame accumulator and its consumer.
// The slave view is the accumulator; the master view is whatever drives and drains it.
interface popcnt_frame_acc_if #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
);
   logic             in_vld;
   logic             in_rdy;
   logic [12:0]      in_cnt;
   logic             in_last;
   logic             out_vld;
   logic             out_rdy;
   logic [ACC_W-1:0] out_sum;
   logic [CNT_W-1:0] out_beats;
   logic             out_over;
   logic             out_err;
   logic             out_sat;

   modport slave (
      input  in_vld, in_cnt, in_last, out_rdy,
      output in_rdy, out_vld, out_sum, out_beats, out_over, out_err, out_sat
   );

   modport master (
      output in_vld, in_cnt, in_last, out_rdy,
      input  in_rdy, out_vld, out_sum, out_beats, out_over, out_err, out_sat
   );
endinterface

// File: rtl/popcnt_frame_acc.sv
// Decodes one-hot popcounts and sums them per frame. Each frame's total, beat count
// and flags land in a one-entry output register.
module popcnt_frame_acc #(
   parameter int          ACC_W  = 16,
   parameter int          CNT_W  = 8,
   parameter int unsigned THRESH = 100
) (
   input logic               clk,
   input logic               rst_n,
   popcnt_frame_acc_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_new;
   logic [ACC_W:0]   acc_sum;
   logic [CNT_W-1:0] beats, beats_new;
   logic             err, sat, err_new, sat_new, beat_max;
   logic [3:0]       ones, dec, value;
   logic             malformed, xfer_in;

   logic             res_vld;
   logic [ACC_W-1:0] res_sum;
   logic [CNT_W-1:0] res_beats;
   logic             res_over, res_err, res_sat;

   assign bus.in_rdy    = !res_vld || bus.out_rdy;
   assign xfer_in       = bus.in_vld && bus.in_rdy;
   assign bus.out_vld   = res_vld;
   assign bus.out_sum   = res_sum;
   assign bus.out_beats = res_beats;
   assign bus.out_over  = res_over;
   assign bus.out_err   = res_err;
   assign bus.out_sat   = res_sat;

   // Count the set bits and remember the index of the last one. The value is
   // trusted only when exactly one bit is set.
   always_comb begin
      ones = '0;
      dec  = '0;
      for (int k = 0; k < 13; k++) begin
         if (bus.in_cnt[k]) begin
            ones = ones + 4'd1;
            dec  = 4'(k);
         end
      end
   end

   assign malformed = (ones != 4'd1);
   assign value     = malformed ? 4'd0 : dec;

   assign acc_sum   = {1'b0, acc} + {{(ACC_W-3){1'b0}}, value};
   assign acc_new   = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
   assign beat_max  = (beats == '1);
   assign beats_new = beat_max ? beats : beats + CNT_W'(1);
   assign err_new   = err | malformed;
   assign sat_new   = sat | acc_sum[ACC_W] | beat_max;

   always_comb begin
      state_nxt = state;
      if (xfer_in) state_nxt = bus.in_last ? IDLE : ACC;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         beats     <= '0;
         err       <= 1'b0;
         sat       <= 1'b0;
         res_vld   <= 1'b0;
         res_sum   <= '0;
         res_beats <= '0;
         res_over  <= 1'b0;
         res_err   <= 1'b0;
         res_sat   <= 1'b0;
      end else begin
         if (res_vld && bus.out_rdy) res_vld <= 1'b0;
         if (xfer_in) begin
            if (bus.in_last) begin
               // A load in the same cycle as a drain overrides the clear above.
               res_vld   <= 1'b1;
               res_sum   <= acc_new;
               res_beats <= beats_new;
               res_over  <= (32'(acc_new) > THRESH);
               res_err   <= err_new;
               res_sat   <= sat_new;
               acc       <= '0;
               beats     <= '0;
               err       <= 1'b0;
               sat       <= 1'b0;
            end else begin
               acc   <= acc_new;
               beats <= beats_new;
               err   <= err_new;
               sat   <= sat_new;
            end
         end
      end
   end
endmodule

// File: tb/tb_popcnt_frame_acc.sv
// Directed and random frames for the accumulator. A frame-level reference model
// predicts every result, and a monitor logs each result the consumer takes.
module tb_popcnt_frame_acc;
   logic clk = 1'b0;
   logic rst_n, rst2_n;
   always #5 clk = ~clk;

   popcnt_frame_acc_if #(.ACC_W(16), .CNT_W(8)) b();
   popcnt_frame_acc_if #(.ACC_W(4),  .CNT_W(2)) b2();

   popcnt_frame_acc #(.ACC_W(16), .CNT_W(8), .THRESH(100)) dut  (.clk(clk), .rst_n(rst_n),  .bus(b));
   popcnt_frame_acc #(.ACC_W(4),  .CNT_W(2), .THRESH(100)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2));

   typedef struct {int sum; int beats; bit over; bit err; bit sat;} res_t;

   int   total = 0;
   int   bad   = 0;
   res_t log_q[$];
   res_t exp_q[$];
   int   m_tot, m_n;
   bit   m_err;

   always @(posedge clk)
      if (rst_n && b.out_vld && b.out_rdy)
         log_q.push_back('{int'(b.out_sum), int'(b.out_beats), b.out_over, b.out_err, b.out_sat});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      total++;
      assert (obs === req) else begin
         bad++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
      end
   endtask

   // Frame total and beat count are clamped at their maxima; sat records
   // that either would have overflowed.
   function automatic res_t expect_res(int tot, int n, bit err, int aw, int cw);
      res_t r;
      int amax = (1 << aw) - 1;
      int cmax = (1 << cw) - 1;
      r.sum   = (tot > amax) ? amax : tot;
      r.beats = (n > cmax) ? cmax : n;
      r.over  = (r.sum > 100);
      r.err   = err;
      r.sat   = (tot > amax) || (n > cmax);
      return r;
   endfunction

   task automatic send(input logic [12:0] cnt, input bit last, input bit rnd);
      int t = 0;
      b.in_vld = 1'b1; b.in_cnt = cnt; b.in_last = last;
      if (rnd) b.out_rdy = 1'($urandom_range(0, 1));
      #1;
      while (!b.in_rdy && t < 50) begin
         @(posedge clk); #1; t++;
         if (rnd) b.out_rdy = 1'($urandom_range(0, 1));
         #1;
      end
      if (t >= 50) check("in_rdy_wait", b.in_rdy, 1);
      @(posedge clk); #1;
      b.in_vld = 1'b0;
      if ($countones(cnt) == 1) m_tot += $clog2(cnt);
      else m_err = 1'b1;
      m_n++;
      if (last) begin
         exp_q.push_back(expect_res(m_tot, m_n, m_err, 16, 8));
         m_tot = 0; m_n = 0; m_err = 1'b0;
      end
   endtask

   task automatic send2(input logic [12:0] cnt, input bit last);
      b2.in_vld = 1'b1; b2.in_cnt = cnt; b2.in_last = last;
      #1;
      check("dut2.in_rdy", b2.in_rdy, 1);
      @(posedge clk); #1;
      b2.in_vld = 1'b0;
   endtask

   initial begin
      int n0, len;
      logic [12:0] c;
      m_tot = 0; m_n = 0; m_err = 1'b0;
      rst_n = 1'b0; rst2_n = 1'b0;
      b.in_vld = 1'b0;  b.in_cnt = '0;  b.in_last = 1'b0;  b.out_rdy = 1'b1;
      b2.in_vld = 1'b0; b2.in_cnt = '0; b2.in_last = 1'b0; b2.out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_vld", b.out_vld, 0);
      check("rst.out_sum", b.out_sum, 0);
      check("rst.out_beats", b.out_beats, 0);
      check("rst.out_over", b.out_over, 0);
      check("rst.out_err", b.out_err, 0);
      check("rst.out_sat", b.out_sat, 0);
      check("rst.in_rdy", b.in_rdy, 1);
      rst_n = 1'b1; rst2_n = 1'b1;

      // three-beat frame
      send(13'(1) << 4, 1'b0, 1'b0);
      send(13'(1) << 12, 1'b0, 1'b0);
      check("f3.no_early_vld", b.out_vld, 0);
      send(13'(1) << 0, 1'b1, 1'b0);
      check("f3.out_vld", b.out_vld, 1);
      check("f3.out_sum", b.out_sum, 16);
      check("f3.out_beats", b.out_beats, 3);
      check("f3.out_over", b.out_over, 0);
      check("f3.out_err", b.out_err, 0);
      check("f3.out_sat", b.out_sat, 0);
      @(posedge clk); #1;
      check("f3.drained", b.out_vld, 0);

      // single-beat frames back to back
      send(13'(1) << 7, 1'b1, 1'b0);
      check("f1.out_sum", b.out_sum, 7);
      check("f1.out_beats", b.out_beats, 1);
      send(13'(1) << 9, 1'b1, 1'b0);
      check("f1b.out_sum", b.out_sum, 9);
      check("f1b.out_beats", b.out_beats, 1);

      // nine beats crossing the threshold, then a new frame with no bubble
      for (int i = 0; i < 9; i++) send(13'(1) << 12, i == 8, 1'b0);
      check("b2b.out_sum", b.out_sum, 108);
      check("b2b.out_over", b.out_over, 1);
      check("b2b.out_beats", b.out_beats, 9);
      check("b2b.in_rdy", b.in_rdy, 1);
      send(13'(1) << 2, 1'b1, 1'b0);
      check("b2b.vld2", b.out_vld, 1);
      check("b2b.sum2", b.out_sum, 2);
      check("b2b.over2", b.out_over, 0);

      // malformed beat
      send(13'h0003, 1'b0, 1'b0);
      send(13'(1) << 5, 1'b1, 1'b0);
      check("mal.out_sum", b.out_sum, 5);
      check("mal.out_beats", b.out_beats, 2);
      check("mal.out_err", b.out_err, 1);
      send(13'(1) << 1, 1'b1, 1'b0);
      check("mal.next_err", b.out_err, 0);
      check("mal.next_sum", b.out_sum, 1);
      send(13'h0000, 1'b1, 1'b0);
      check("mal.zero_sum", b.out_sum, 0);
      check("mal.zero_err", b.out_err, 1);
      @(posedge clk); #1;

      // backpressure
      b.out_rdy = 1'b0;
      send(13'(1) << 6, 1'b1, 1'b0);
      n0 = log_q.size();
      b.in_vld = 1'b1; b.in_cnt = 13'(1) << 9; b.in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp.in_rdy", b.in_rdy, 0);
         check("bp.out_vld", b.out_vld, 1);
         check("bp.out_sum", b.out_sum, 6);
         check("bp.out_beats", b.out_beats, 1);
      end
      b.out_rdy = 1'b1;
      send(13'(1) << 9, 1'b1, 1'b0);
      check("bp.vld2", b.out_vld, 1);
      check("bp.sum2", b.out_sum, 9);
      @(posedge clk); #1;
      check("bp.drained", b.out_vld, 0);
      check("bp.taken", log_q.size() - n0, 2);
      if (log_q.size() - n0 == 2) begin
         check("bp.first", log_q[n0].sum, 6);
         check("bp.second", log_q[n0+1].sum, 9);
      end

      // random frames with random backpressure
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) c = 13'($urandom);
            else c = 13'(1) << $urandom_range(0, 12);
            send(c, i == len - 1, 1'b1);
         end
      end
      b.out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rnd.count", log_q.size(), exp_q.size());
      if (log_q.size() == exp_q.size())
         for (int i = 0; i < exp_q.size(); i++) begin
            check("rnd.sum", log_q[i].sum, exp_q[i].sum);
            check("rnd.beats", log_q[i].beats, exp_q[i].beats);
            check("rnd.over", log_q[i].over, exp_q[i].over);
            check("rnd.err", log_q[i].err, exp_q[i].err);
            check("rnd.sat", log_q[i].sat, exp_q[i].sat);
         end

      // saturation on the narrow instance, then reset mid-frame
      for (int i = 0; i < 5; i++) send2(13'(1) << 12, i == 4);
      check("sat.out_vld", b2.out_vld, 1);
      check("sat.out_sum", b2.out_sum, 15);
      check("sat.out_beats", b2.out_beats, 3);
      check("sat.out_sat", b2.out_sat, 1);
      check("sat.out_over", b2.out_over, 0);
      send2(13'(1) << 1, 1'b0);
      send2(13'(1) << 1, 1'b0);
      rst2_n = 1'b0;
      @(posedge clk); #1;
      check("srst.out_vld", b2.out_vld, 0);
      check("srst.out_sum", b2.out_sum, 0);
      rst2_n = 1'b1;
      send2(13'(1) << 3, 1'b1);
      check("srst.sum", b2.out_sum, 3);
      check("srst.beats", b2.out_beats, 1);
      check("srst.sat", b2.out_sat, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
